// File: rtl/n4v_bus_pkg.sv
// Shared types and bus widths for the n4v bus arbiter.
package n4v_bus_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_TURN
  } state_e;

endpackage

// File: rtl/n4v_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping.
module n4v_rr_pick #(
  parameter int NM    = 3,
  parameter int IDX_W = $clog2(NM)
) (
  input  logic [NM-1:0]    req,
  input  logic [IDX_W-1:0] last,
  output logic [NM-1:0]    gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] j;

  // NOTE: every output and temporary gets a default before the loop so no path
  // through this block leaves a value unassigned, which would infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    // Offset k=NM brings us back to 'last' itself, so it has lowest priority.
    for (int k = 1; k <= NM; k++) begin
      j = IDX_W'((int'(last) + k) % NM);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/n4v_bus_arbiter.sv
// Round-robin owner of the single MMU/memory port: whole-cycle grants, lock for
// TAS, forced turnaround between owners and an ack watchdog.
module n4v_bus_arbiter
  import n4v_bus_pkg::*;
#(
  parameter int NM     = 3,
  parameter int TO_W   = 10,
  parameter int TO_CYC = 1000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NM-1:0]       m_cyc_i,
  input  logic [NM-1:0]       m_stb_i,
  input  logic [NM-1:0]       m_we_i,
  input  logic [NM-1:0]       m_lock_i,
  input  logic [NM*ADR_W-1:0] m_adr_i,
  input  logic [NM*DAT_W-1:0] m_dat_i,
  output logic [NM-1:0]       m_ack_o,
  output logic [NM-1:0]       m_err_o,
  output logic [DAT_W-1:0]    m_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADR_W-1:0]    s_adr_o,
  output logic [DAT_W-1:0]    s_dat_o,
  input  logic                s_ack_i,
  input  logic [DAT_W-1:0]    s_dat_i,
  output logic [NM-1:0]       gnt_o
);

  localparam int IDX_W = $clog2(NM);

  state_e           state_q, state_d;
  logic [NM-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;

  logic [NM-1:0]    pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             g_cyc, g_stb, g_we, g_lock, expire;

  n4v_rr_pick #(.NM(NM), .IDX_W(IDX_W)) u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // gnt_q is all-zero outside BUSY, so these reductions also gate idle/turnaround.
  assign g_cyc  = |(gnt_q & m_cyc_i);
  assign g_stb  = |(gnt_q & m_stb_i);
  assign g_we   = |(gnt_q & m_we_i);
  assign g_lock = |(gnt_q & m_lock_i);

  // An ack in the expiry cycle wins over the watchdog.
  assign expire = (state_q == ST_BUSY) && (wdog_q == TO_W'(TO_CYC - 1)) && !s_ack_i;

  assign s_cyc_o = g_cyc & ~expire;
  assign s_stb_o = g_stb & ~expire;
  assign s_we_o  = g_we;
  assign m_ack_o = gnt_q & {NM{s_ack_i}};
  assign m_err_o = gnt_q & {NM{expire}};
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < NM; k++) begin
      s_adr_o = s_adr_o | (m_adr_i[k*ADR_W +: ADR_W] & {ADR_W{gnt_q[k]}});
      s_dat_o = s_dat_o | (m_dat_i[k*DAT_W +: DAT_W] & {DAT_W{gnt_q[k]}});
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = pick_gnt;
          last_d  = pick_idx;
          wdog_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Locked idle cycles count too, so a stuck lock still times out.
        if (s_ack_i) wdog_d = '0;
        else if (g_stb || (g_lock && !g_cyc)) wdog_d = wdog_q + TO_W'(1);
        if (expire || (!g_cyc && !g_lock)) begin
          gnt_d   = '0;
          state_d = ST_TURN;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NM - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_n4v_bus_arbiter.sv
// Directed bench for n4v_bus_arbiter: single read, round-robin, walk, TAS lock,
// watchdog expiry and asynchronous reset mid-cycle.
module tb_n4v_bus_arbiter;

  localparam int NM = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NM-1:0]   m_cyc_i, m_stb_i, m_we_i, m_lock_i;
  logic [NM*32-1:0] m_adr_i;
  logic [NM*16-1:0] m_dat_i;
  logic [NM-1:0]   m_ack_o, m_err_o, gnt_o;
  logic [15:0]     m_dat_o, s_dat_o, s_dat_i;
  logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0]     s_adr_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] adr_tab [NM];

  n4v_bus_arbiter #(.NM(NM), .TO_W(10), .TO_CYC(16)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_lock_i (m_lock_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_dat_o  (m_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_ack_i  (s_ack_i),
    .s_dat_i  (s_dat_i),
    .gnt_o    (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One owner: granted from IDLE, acked at once, drops cyc, re-requests in TURN.
  task automatic serve(input int idx);
    logic [NM-1:0] g;
    g = NM'(1) << idx;
    tick();
    check("rr_gnt", gnt_o, g);
    check("rr_cyc", s_cyc_o, 1'b1);
    check("rr_adr", s_adr_o, adr_tab[idx]);
    s_ack_i = 1'b1;
    #1 check("rr_ack", m_ack_o, g);
    tick();
    s_ack_i = 1'b0;
    m_cyc_i[idx] = 1'b0;
    m_stb_i[idx] = 1'b0;
    #1 check("rr_drop_cyc", s_cyc_o, 1'b0);
    tick();
    check("rr_turn_gnt", gnt_o, '0);
    check("rr_turn_cyc", s_cyc_o, 1'b0);
    m_cyc_i[idx] = 1'b1;
    m_stb_i[idx] = 1'b1;
    tick();
  endtask

  initial begin
    adr_tab[0] = 32'h1000_0010;
    adr_tab[1] = 32'h2000_0020;
    adr_tab[2] = 32'h3000_0030;
    m_adr_i  = {32'h3000_0030, 32'h2000_0020, 32'h1000_0010};
    m_dat_i  = {16'hC333, 16'hB222, 16'hA111};
    rst_ni   = 1'b0;
    m_cyc_i  = '0;
    m_stb_i  = '0;
    m_we_i   = '0;
    m_lock_i = '0;
    s_ack_i  = 1'b0;
    s_dat_i  = 16'h0;

    // Reset state
    #1;
    check("rst_gnt", gnt_o, '0);
    check("rst_cyc", s_cyc_o, 1'b0);
    check("rst_ack", m_ack_o, '0);
    check("rst_err", m_err_o, '0);
    repeat (2) tick();
    rst_ni = 1'b1;

    // 1. CPU-only read with three wait states
    m_cyc_i = 3'b001;
    m_stb_i = 3'b001;
    #1 check("t1_latency_cyc", s_cyc_o, 1'b0);
    tick();
    check("t1_gnt", gnt_o, 3'b001);
    check("t1_cyc", s_cyc_o, 1'b1);
    check("t1_adr", s_adr_o, 32'h1000_0010);
    check("t1_noack", m_ack_o, '0);
    tick();
    tick();
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 16'h1234;
    #1 check("t1_ack", m_ack_o, 3'b001);
    check("t1_rdata", m_dat_o, 16'h1234);
    tick();
    s_ack_i = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    #1 check("t1_drop_cyc", s_cyc_o, 1'b0);
    tick();
    check("t1_turn_gnt", gnt_o, '0);
    tick();
    check("t1_idle_gnt", gnt_o, '0);

    // 2. All three request continuously, starting from last=2
    rst_ni = 1'b0;
    tick();
    rst_ni  = 1'b1;
    m_cyc_i = 3'b111;
    m_stb_i = 3'b111;
    serve(0);
    serve(1);
    serve(2);
    serve(0);

    // 3. DMA write walk: 8 beats in one cyc, CPU waiting with a locked TAS queued
    m_cyc_i  = 3'b011;
    m_stb_i  = 3'b011;
    m_we_i   = 3'b010;
    m_lock_i = 3'b001;
    tick();
    for (int b = 0; b < 8; b++) begin
      check("t3_gnt", gnt_o, 3'b010);
      check("t3_we", s_we_o, 1'b1);
      check("t3_wdata", s_dat_o, 16'hB222);
      s_ack_i = 1'b1;
      #1 check("t3_ack", m_ack_o, 3'b010);
      tick();
      s_ack_i    = 1'b0;
      m_stb_i[1] = 1'b0;
      #1 check("t3_hold_gnt", gnt_o, 3'b010);
      check("t3_stb_low", s_stb_o, 1'b0);
      tick();
      m_stb_i[1] = 1'b1;
    end
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    #1 check("t3_drop_cyc", s_cyc_o, 1'b0);
    tick();
    check("t3_turn_gnt", gnt_o, '0);
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    m_we_i     = '0;
    tick();
    tick();

    // 4. TAS: CPU holds the grant with lock across a 2-cycle cyc drop
    check("t4_gnt", gnt_o, 3'b001);
    s_ack_i = 1'b1;
    #1 check("t4_rd_ack", m_ack_o, 3'b001);
    tick();
    s_ack_i    = 1'b0;
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    #1 check("t4_lock_gnt1", gnt_o, 3'b001);
    check("t4_lock_cyc", s_cyc_o, 1'b0);
    tick();
    check("t4_lock_gnt2", gnt_o, 3'b001);
    tick();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    m_we_i[0]  = 1'b1;
    #1 check("t4_wr_gnt", gnt_o, 3'b001);
    check("t4_wr_cyc", s_cyc_o, 1'b1);
    check("t4_wr_we", s_we_o, 1'b1);
    s_ack_i = 1'b1;
    #1 check("t4_wr_ack", m_ack_o, 3'b001);
    tick();
    s_ack_i    = 1'b0;
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    m_we_i[0]  = 1'b0;
    m_lock_i   = '0;
    #1 check("t4_drop_cyc", s_cyc_o, 1'b0);
    tick();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    tick();
    tick();

    // 5. Watchdog: DMA never acked, error on the 16th BUSY cycle
    check("t5_gnt", gnt_o, 3'b010);
    for (int i = 0; i < 15; i++) begin
      check("t5_no_err", m_err_o, '0);
      tick();
    end
    check("t5_err", m_err_o, 3'b010);
    check("t5_err_cyc", s_cyc_o, 1'b0);
    check("t5_err_stb", s_stb_o, 1'b0);
    tick();
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    #1 check("t5_err_pulse_end", m_err_o, '0);
    check("t5_turn_gnt", gnt_o, '0);
    tick();
    tick();
    check("t5_next_gnt", gnt_o, 3'b001);

    // 6. Asynchronous reset during BUSY
    check("t6_cyc_before", s_cyc_o, 1'b1);
    #1 rst_ni = 1'b0;
    s_ack_i = 1'b1;
    #1 check("t6_rst_cyc", s_cyc_o, 1'b0);
    check("t6_rst_gnt", gnt_o, '0);
    check("t6_rst_ack", m_ack_o, '0);
    check("t6_rst_err", m_err_o, '0);
    tick();
    rst_ni  = 1'b1;
    s_ack_i = 1'b0;
    m_cyc_i = 3'b011;
    m_stb_i = 3'b011;
    tick();
    check("t6_restart_gnt", gnt_o, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
